// File: rtl/param_regfile.sv
// param_regfile: parametrised architectural register file.
//
// One synchronous write port and two combinational read ports.
// An optional register is hardwired to zero, and the read ports can
// optionally bypass the write data in the write cycle.
//
// Ports:
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous active-high reset, clears every register
//   wr_en      in   1      write enable
//   wr_addr    in   AW     write address
//   wr_data    in   WIDTH  write data, stored unmodified
//   rd_addr_a  in   AW     read address, port A
//   rd_addr_b  in   AW     read address, port B
//   rd_data_a  out  WIDTH  read data, port A (combinational)
//   rd_data_b  out  WIDTH  read data, port B (combinational)
//
// regfile_cell: one WIDTH-bit storage word with a write enable and a
// synchronous clear. Reset takes priority over the enable.

module regfile_cell #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk) begin
        if (reset)
            q <= '0;
        else if (en)
            q <= d;
    end
endmodule

module param_regfile #(
    parameter int WIDTH    = 64,
    parameter int DEPTH    = 32,
    // Derived from DEPTH; leave at its default.
    parameter int AW       = $clog2(DEPTH),
    parameter int ZERO_EN  = 1,
    parameter int ZERO_IDX = 31,
    parameter int BYPASS   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b
);
    // Catch illegal configurations at elaboration.
    if (DEPTH < 2 || DEPTH > 64) begin : g_bad_depth
        $error("param_regfile: DEPTH must be in 2..64");
    end
    if (AW != $clog2(DEPTH)) begin : g_bad_aw
        $error("param_regfile: AW must equal $clog2(DEPTH)");
    end
    if (ZERO_EN != 0 && (ZERO_IDX < 0 || ZERO_IDX >= DEPTH)) begin : g_bad_zidx
        $error("param_regfile: ZERO_IDX must be below DEPTH");
    end

    logic [DEPTH-1:0][WIDTH-1:0] regs;
    logic [DEPTH-1:0]            wr_sel;
    logic                        wr_ok;
    logic                        byp_ok;

    // One-hot write decode. Addresses >= DEPTH match no slot, and the
    // zero register never gets a select, so both cases drop out of
    // wr_sel without extra range logic.
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        if (ZERO_EN != 0 && i == ZERO_IDX) begin : g_zero
            assign wr_sel[i] = 1'b0;
            assign regs[i]   = '0;
        end else begin : g_reg
            assign wr_sel[i] = wr_en && (wr_addr == AW'(i));
            regfile_cell #(.WIDTH(WIDTH)) u_cell (
                .clk   (clk),
                .reset (reset),
                .en    (wr_sel[i]),
                .d     (wr_data),
                .q     (regs[i])
            );
        end
    end

    // A write that actually lands this cycle; only such a write may be
    // forwarded. Reset kills the write, so it kills the bypass too.
    assign wr_ok  = |wr_sel;
    assign byp_ok = (BYPASS != 0) && wr_ok && !reset;

    // Read mux: unmatched (out-of-range) addresses fall through to zero.
    function automatic logic [WIDTH-1:0] sel_word(
        input logic [DEPTH-1:0][WIDTH-1:0] r,
        input logic [AW-1:0]               a
    );
        logic [WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < DEPTH; i++)
            if (a == AW'(i))
                v = r[i];
        return v;
    endfunction

    assign rd_data_a = (byp_ok && rd_addr_a == wr_addr) ? wr_data : sel_word(regs, rd_addr_a);
    assign rd_data_b = (byp_ok && rd_addr_b == wr_addr) ? wr_data : sel_word(regs, rd_addr_b);

endmodule

// File: tb/tb_param_regfile.sv
// Testbench for param_regfile. Five instances share one stimulus stream:
//   0: DEPTH32 W64 BYPASS1 ZERO_EN1 ZIDX31
//   1: DEPTH32 W64 BYPASS0 ZERO_EN1 ZIDX31
//   2: DEPTH32 W64 BYPASS1 ZERO_EN0
//   3: DEPTH32 W64 BYPASS0 ZERO_EN0
//   4: DEPTH24 W16 BYPASS1 ZERO_EN1 ZIDX0
module tb_param_regfile;

    localparam int N = 5;
    localparam int P_DEPTH [N] = '{32, 32, 32, 32, 24};
    localparam int P_BYP   [N] = '{1, 0, 1, 0, 1};
    localparam int P_ZEN   [N] = '{1, 1, 0, 0, 1};
    localparam int P_ZIDX  [N] = '{31, 31, 31, 31, 0};
    localparam logic [63:0] P_MASK [N] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                                           64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                                           64'h0000_0000_0000_FFFF};

    logic        clk = 1'b0;
    logic        reset, wr_en;
    logic [4:0]  wr_addr, ra, rb;
    logic [63:0] wr_data;
    logic [63:0] da [N];
    logic [63:0] db [N];
    logic [15:0] da4, db4;

    int checks = 0;
    int errors = 0;

    logic [63:0] mdl [N][32];

    always #5 clk = ~clk;

    param_regfile #(.WIDTH(64), .DEPTH(32), .ZERO_EN(1), .ZERO_IDX(31), .BYPASS(1)) u0 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(ra), .rd_addr_b(rb), .rd_data_a(da[0]), .rd_data_b(db[0]));
    param_regfile #(.WIDTH(64), .DEPTH(32), .ZERO_EN(1), .ZERO_IDX(31), .BYPASS(0)) u1 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(ra), .rd_addr_b(rb), .rd_data_a(da[1]), .rd_data_b(db[1]));
    param_regfile #(.WIDTH(64), .DEPTH(32), .ZERO_EN(0), .ZERO_IDX(31), .BYPASS(1)) u2 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(ra), .rd_addr_b(rb), .rd_data_a(da[2]), .rd_data_b(db[2]));
    param_regfile #(.WIDTH(64), .DEPTH(32), .ZERO_EN(0), .ZERO_IDX(31), .BYPASS(0)) u3 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(ra), .rd_addr_b(rb), .rd_data_a(da[3]), .rd_data_b(db[3]));
    param_regfile #(.WIDTH(16), .DEPTH(24), .ZERO_EN(1), .ZERO_IDX(0), .BYPASS(1)) u4 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data[15:0]),
        .rd_addr_a(ra), .rd_addr_b(rb), .rd_data_a(da4), .rd_data_b(db4));

    assign da[4] = {48'd0, da4};
    assign db[4] = {48'd0, db4};

    // ---------------- reference model ----------------
    function automatic logic writable(int k, logic [4:0] a);
        if (int'(a) >= P_DEPTH[k]) return 1'b0;
        if (P_ZEN[k] != 0 && int'(a) == P_ZIDX[k]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [63:0] exp_rd(int k, logic [4:0] a);
        if (int'(a) >= P_DEPTH[k]) return 64'd0;
        if (P_ZEN[k] != 0 && int'(a) == P_ZIDX[k]) return 64'd0;
        if (P_BYP[k] != 0 && wr_en && !reset && a == wr_addr && writable(k, wr_addr))
            return wr_data & P_MASK[k];
        return mdl[k][a];
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic we, input logic [4:0] wa,
                         input logic [63:0] wd, input logic [4:0] a, input logic [4:0] b);
        reset = r; wr_en = we; wr_addr = wa; wr_data = wd; ra = a; rb = b;
        #1;
    endtask

    // Check every instance against the model, pre-edge.
    task automatic check_all(input string tag);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("%s_dut%0d_a", tag, k), da[k], exp_rd(k, ra));
            chk($sformatf("%s_dut%0d_b", tag, k), db[k], exp_rd(k, rb));
        end
    endtask

    // Advance one rising edge, update the model, return to the falling edge.
    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < N; k++) begin
            if (reset) begin
                for (int i = 0; i < 32; i++) mdl[k][i] = 64'd0;
            end else if (wr_en && writable(k, wr_addr)) begin
                mdl[k][wr_addr] = wr_data & P_MASK[k];
            end
        end
        @(negedge clk);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        rst, we;
        logic [4:0]  wa;
        logic [63:0] wd;
        logic [4:0]  a, b;
        logic [63:0] ea, eb;   // instance 0 (bypass, zero reg)
        logic [63:0] ea_nb;    // instance 1 port A (no bypass)
    } vec_t;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    vec_t tbl [13];

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 5'd5,  64'd9854768, 5'd5,  5'd5, 64'd9854768, 64'd9854768, 64'd0};
        tbl[1]  = '{1'b1, 1'b1, 5'd7,  64'd550,     5'd5,  5'd7, 64'd9854768, 64'd0,       64'd9854768};
        tbl[2]  = '{1'b0, 1'b0, 5'd7,  64'd0,       5'd5,  5'd7, 64'd0,       64'd0,       64'd0};
        tbl[3]  = '{1'b0, 1'b1, 5'd3,  64'd420,     5'd3,  5'd3, 64'd420,     64'd420,     64'd0};
        tbl[4]  = '{1'b0, 1'b0, 5'd3,  64'd69,      5'd3,  5'd3, 64'd420,     64'd420,     64'd420};
        tbl[5]  = '{1'b0, 1'b0, 5'd3,  64'd69,      5'd3,  5'd3, 64'd420,     64'd420,     64'd420};
        tbl[6]  = '{1'b0, 1'b0, 5'd3,  64'd69,      5'd3,  5'd3, 64'd420,     64'd420,     64'd420};
        tbl[7]  = '{1'b0, 1'b1, 5'd9,  64'd215687,  5'd9,  5'd9, 64'd215687,  64'd215687,  64'd0};
        tbl[8]  = '{1'b0, 1'b0, 5'd9,  64'd0,       5'd9,  5'd9, 64'd215687,  64'd215687,  64'd215687};
        tbl[9]  = '{1'b0, 1'b1, 5'd31, ONES,        5'd31, 5'd3, 64'd0,       64'd420,     64'd0};
        tbl[10] = '{1'b0, 1'b0, 5'd31, 64'd0,       5'd31, 5'd9, 64'd0,       64'd215687,  64'd0};
        tbl[11] = '{1'b0, 1'b1, 5'd4,  64'd77,      5'd3,  5'd4, 64'd420,     64'd77,      64'd420};
        tbl[12] = '{1'b0, 1'b0, 5'd4,  64'd0,       5'd4,  5'd4, 64'd77,      64'd77,      64'd77};
    end

    initial begin
        for (int k = 0; k < N; k++)
            for (int i = 0; i < 32; i++) mdl[k][i] = 64'd0;

        // Initial reset, two edges.
        drive(1'b1, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0);
        tick();
        tick();

        // Reset state: every address reads zero on every instance.
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 1'b0, 5'd0, 64'd0, 5'(i), 5'(31 - i));
            for (int k = 0; k < N; k++) begin
                chk($sformatf("rst_dut%0d_a%0d", k, i), da[k], 64'd0);
                chk($sformatf("rst_dut%0d_b%0d", k, i), db[k], 64'd0);
            end
        end

        // Table vectors.
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].rst, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].a, tbl[i].b);
            chk($sformatf("vec%0d_a", i), da[0], tbl[i].ea);
            chk($sformatf("vec%0d_b", i), db[0], tbl[i].eb);
            chk($sformatf("vec%0d_nb_a", i), da[1], tbl[i].ea_nb);
            check_all($sformatf("vec%0d", i));
            tick();
        end

        // Zero register disabled: all-ones bypassed in the write cycle, then stored.
        drive(1'b0, 1'b1, 5'd31, ONES, 5'd31, 5'd31);
        chk("nozero_byp", da[2], ONES);
        chk("nozero_nobyp_old", da[3], ONES); // already written by vec9
        chk("zero_byp", da[0], 64'd0);
        tick();
        drive(1'b0, 1'b0, 5'd31, 64'd0, 5'd31, 5'd31);
        chk("nozero_after", db[2], ONES);
        chk("zero_after", db[0], 64'd0);

        // Fresh reset so the no-bypass zero-disabled instance sees the write cycle.
        drive(1'b1, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0);
        tick();
        drive(1'b0, 1'b1, 5'd31, ONES, 5'd31, 5'd31);
        chk("nobyp_old", da[3], 64'd0);
        chk("byp_new", da[2], ONES);
        tick();
        drive(1'b0, 1'b0, 5'd31, 64'd0, 5'd31, 5'd31);
        chk("nobyp_new", da[3], ONES);

        // DEPTH=24: preload some words, write out of range, confirm nothing moved.
        for (int i = 0; i < 24; i++) begin
            drive(1'b0, 1'b1, 5'(i), 64'(16'h0100 + i), 5'(i), 5'd0);
            tick();
        end
        drive(1'b0, 1'b1, 5'd30, 64'h1234, 5'd30, 5'd23);
        chk("d24_oor_byp", da[4], 64'd0);
        chk("d24_r23_pre", db[4], 64'h0117);
        tick();
        for (int i = 0; i < 24; i++) begin
            drive(1'b0, 1'b0, 5'd0, 64'd0, 5'(i), 5'd30);
            chk($sformatf("d24_keep%0d", i), da[4], (i == 0) ? 64'd0 : 64'(16'h0100 + i));
            chk($sformatf("d24_a30_%0d", i), db[4], 64'd0);
        end
        drive(1'b0, 1'b1, 5'd23, 64'hBEEF, 5'd23, 5'd22);
        chk("d24_beef_byp", da[4], 64'hBEEF);
        tick();
        drive(1'b0, 1'b0, 5'd0, 64'd0, 5'd23, 5'd23);
        chk("d24_beef", da[4], 64'hBEEF);
        chk("d24_beef_b", db[4], 64'hBEEF);

        // Random soak against the model, all configurations.
        for (int c = 0; c < 2000; c++) begin
            drive(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  {$urandom, $urandom}, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 7) == 0) rb = ra;
            if ($urandom_range(0, 3) == 0) ra = wr_addr;
            #1;
            check_all("soak");
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
